// File: rtl/stop_watch_display.sv
// Six-digit multiplexed 7-segment driver for an hh:mm:ss stopwatch.
// Each frame shows one snapshot of the inputs, taken when the digit scan wraps.
module stop_watch_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic       blank_i,
  output logic [6:0] seg_o,
  output logic [5:0] dig_o,
  output logic       frame_o
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PrescMax = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    dig_q, dig_d;
  logic          frame_q, frame_d;

  logic          tc, wrap;
  logic [5:0]    val, tens;
  logic [3:0]    ones, digit;
  logic          oor;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Scan timing and snapshot capture; the snapshot only moves on a 5->0 wrap.
  always_comb begin
    tc      = (presc_q == PrescMax);
    wrap    = tc && (idx_q == 3'd5);
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tc) begin
      idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    end
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (wrap) begin
      hour_d = hour_i;
      min_d  = min_i;
      sec_d  = sec_i;
    end
    frame_d = wrap;
  end

  // Digit decode for the slot currently addressed by idx.
  always_comb begin
    val = 6'd0;
    oor = 1'b0;
    case (idx_q)
      3'd0, 3'd1: begin
        val = sec_q;
        oor = (sec_q > 6'd59);
      end
      3'd2, 3'd3: begin
        val = min_q;
        oor = (min_q > 6'd59);
      end
      3'd4, 3'd5: begin
        val = {2'b00, hour_q};
        oor = (hour_q > 4'd11);
      end
      default: begin
        val = 6'd0;
        oor = 1'b0;
      end
    endcase
    tens  = val / 6'd10;
    ones  = 4'(val % 6'd10);
    digit = idx_q[0] ? 4'(tens) : ones;
    seg_d = enc7(digit);
    if (oor) begin
      seg_d = 7'h40;
    end else if ((idx_q == 3'd5) && (tens == 6'd0)) begin
      seg_d = 7'h00;
    end
    dig_d = blank_i ? 6'b000000 : (6'b000001 << idx_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      hour_q  <= 4'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      seg_q   <= 7'h00;
      dig_q   <= 6'b000000;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;

endmodule
